fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
Sequential multiply-accumulate FIR engine that sits directly downstream of the adder datapath in the FIR filter. It accepts one input sample per transaction and shifts it into a TAPS-deep delay line. It then makes one multiply-add pass per tap through a single shared adder/accumulator and presents one filtered output word. A valid/ready handshake is used on both the input and output sides, and coefficients are loadable at runtime through a simple write port.

Parameters:
DATA_W, 8, input sample width, signed two's complement
COEF_W, 8, coefficient width, signed two's complement
TAPS, 4, number of filter taps (>=2)
ACC_W, 18, accumulator/output width; must be >= DATA_W+COEF_W+clog2(TAPS)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input sample present
in_ready  output  1  engine can accept a sample
in_data  input  DATA_W  signed input sample
coef_we  input  1  coefficient write strobe
coef_addr  input  clog2(TAPS)  coefficient index
coef_data  input  COEF_W  signed coefficient value
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts result
out_data  output  ACC_W  signed filtered result
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset state: state=IDLE, delay line x[0..TAPS-1]=0, coefficients c[0..TAPS-1]=0, acc=0, idx=0, out_valid=0, out_data=0, busy=0. in_ready=1 once rst_n deasserts.
- FSM states: IDLE, MAC, OUT.
- in_ready = (state==IDLE), combinational from state.
- IDLE:
  - On in_valid&&in_ready at edge E0: x[0]<=in_data, x[k]<=x[k-1], acc<=0, idx<=0, state<=MAC.
  - in_valid low: remain in IDLE.
- MAC:
  - At each edge: acc<=acc+sext(x[idx]*c[idx]), idx<=idx+1.
  - At the edge where idx==TAPS-1, the final add completes and state<=OUT, out_valid<=1, out_data<=final sum.
  - Exactly TAPS MAC edges occur. out_valid is first visible after edge E0+TAPS, giving a latency of TAPS+1 cycles from the accept cycle.
- OUT:
  - out_valid=1. out_data is held stable while out_ready=0, for an unbounded stall.
  - On out_valid&&out_ready: out_valid<=0, state<=IDLE.
  - There is no overlap, so the next sample can be accepted no earlier than the cycle after the output handshake.
- Throughput: one sample per TAPS+2 cycles with out_ready held high.
- Arithmetic:
  - Signed multiply, DATA_W x COEF_W -> DATA_W+COEF_W bits, sign-extended to ACC_W.
  - No rounding and no saturation; ACC_W sizing guarantees no overflow.
  - idx does not wrap past TAPS-1 within a pass.
- Coefficient writes:
  - Accepted only in IDLE: c[coef_addr]<=coef_data.
  - Ignored in MAC and OUT.
  - Ignored if coef_addr>=TAPS.
  - A write in the same IDLE cycle as a sample accept takes effect and is used by that pass.
- Delay line shifts only on an input accept. Stalls and coefficient writes do not disturb it.
- Reset mid-operation: any state returns to IDLE immediately. Delay line, coefficients and acc are cleared, and a pending output is discarded (out_valid drops asynchronously).
- in_valid while not IDLE: no effect. The sample stays on the bus for the upstream to hold until in_ready.

Test Plan:
- Impulse: TAPS=4, c={1,2,3,4}; feed 1,0,0,0,0 with out_ready=1 -> outputs 1,2,3,4,0 in order, each out_valid 5 cycles after its accept cycle.
- Extreme values: all c=-128; feed -128 four times -> 4th output = +65536 (0x10000), with no overflow in 18 bits. Then set all c=127 and feed 127 four times -> final output 64516.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1 throughout. Releasing out_ready gives one handshake, then in_ready=1 on the next cycle.
- Coefficient gating:
  - Write c[0]=5 during MAC -> ignored, output unchanged.
  - Write c[0]=5 in the same IDLE cycle as accept of sample 2 (delay line previously zero) -> output 10.
- Async reset: assert rst_n low mid-MAC (idx=2) -> out_valid=0 and busy=0 immediately. After release, impulse 1 with reloaded c={1,2,3,4} -> output 1, proving the delay line was cleared.
- Back-to-back with in_valid held high on samples 3,-2 -> second accept occurs exactly one cycle after the first output handshake. With c={1,2,3,4} and a prior zero history, outputs are 3 and 4.

Source files
------------

// File: rtl/fir_mac_seq.sv
// Sequential multiply-accumulate FIR engine.
// Each accepted sample shifts into a TAPS-deep delay line. The engine then makes one
// multiply-add pass per tap through a single shared accumulator and holds the filtered
// result on a valid/ready output until it is taken. Coefficients can be rewritten while idle.
module fir_mac_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned ACC_W  = 18,
  localparam int unsigned IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [IDX_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     busy
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0]  c_q [TAPS];
  logic signed [COEF_W-1:0]  c_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   sum;
  logic                      last_tap;
  logic                      coef_fire;

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Single shared multiplier; the signed product is sign-extended into the accumulator.
  assign prod     = x_q[idx_q] * c_q[idx_q];
  assign sum      = acc_q + ACC_W'(prod);
  assign last_tap = (idx_q == IDX_W'(TAPS - 1));

  // Out-of-range addresses are dropped so a non-power-of-two TAPS never writes past the array.
  assign coef_fire = in_ready && coef_we && (32'(coef_addr) < TAPS);

  // Next-state logic for the FSM, delay line, coefficient bank and accumulator.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // A write in the accept cycle lands before the first MAC edge, so that pass uses it.
    if (coef_fire) begin
      c_d[coef_addr] = coef_data;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = sum;
        if (last_tap) begin
          state_d     = StOut;
          out_valid_d = 1'b1;
          out_data_d  = sum;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset clears everything, including any result not yet taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      x_q         <= x_d;
      c_q         <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: table-driven samples with scoreboarded outputs,
// plus hand-written sequences for backpressure, coefficient gating, reset and back-to-back.
module tb_fir_mac_seq;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned TAPS   = 4;
  localparam int unsigned ACC_W  = 18;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     coef_we = 1'b0;
  logic [1:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [ACC_W-1:0]  out_data;
  logic                     busy;

  fir_mac_seq #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cyc = -1;
  int exp_q[$];
  int acc_cyc_q[$];
  bit ov_prev = 1'b0;

  typedef struct {
    bit load;
    int cval;
    int sample;
    int exp;
  } vec_t;

  vec_t tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_cyc_q.size() == 0) chk("out_valid_without_accept", int'(out_valid), 0);
        else chk("latency", cyc - acc_cyc_q.pop_front(), TAPS + 1);
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) chk("output_without_accept", int'(out_valid), 0);
        else chk("out_data", int'(out_data), exp_q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle_busy", int'(busy), 0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wait_out_valid", int'(out_valid), 1);
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    int cv[4];
    cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
    for (int i = 0; i < 4; i++) begin
      coef_we   = 1'b1;
      coef_addr = 2'(i);
      coef_data = 8'(cv[i]);
      tick();
    end
    coef_we = 1'b0;
  endtask

  // Offer one sample (optionally with a c[0] write in the same cycle) and score it.
  task automatic send(input int s, input int exp, input bit we = 1'b0, input int cd = 0);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = 8'(s);
    coef_we   = we;
    coef_addr = '0;
    coef_data = 8'(cd);
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", int'(in_ready), 1);
    end else begin
      exp_q.push_back(exp);
      acc_cyc_q.push_back(cyc);
    end
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;

    // Reset values, observed while reset is held and just after release.
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_data", int'(out_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_busy", int'(busy), 0);

    // Impulse then extreme values; the delay line carries across rows.
    tbl[0]  = '{1'b0, 0, 1, 1};
    tbl[1]  = '{1'b0, 0, 0, 2};
    tbl[2]  = '{1'b0, 0, 0, 3};
    tbl[3]  = '{1'b0, 0, 0, 4};
    tbl[4]  = '{1'b0, 0, 0, 0};
    tbl[5]  = '{1'b1, -128, -128, 16384};
    tbl[6]  = '{1'b0, 0, -128, 32768};
    tbl[7]  = '{1'b0, 0, -128, 49152};
    tbl[8]  = '{1'b0, 0, -128, 65536};
    tbl[9]  = '{1'b1, 127, 127, -32639};
    tbl[10] = '{1'b0, 0, 127, -254};
    tbl[11] = '{1'b0, 0, 127, 32131};
    tbl[12] = '{1'b0, 0, 127, 64516};

    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 13; i++) begin
      wait_idle();
      if (tbl[i].load) load_coefs(tbl[i].cval, tbl[i].cval, tbl[i].cval, tbl[i].cval);
      send(tbl[i].sample, tbl[i].exp);
    end
    wait_idle();

    // Backpressure: x = {2,127,127,127}, c = {1,2,3,4} -> 1145 held through the stall.
    load_coefs(1, 2, 3, 4);
    out_ready = 1'b0;
    send(2, 1145);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_out_data", int'(out_data), 1145);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("after_hs_in_ready", int'(in_ready), 1);
    chk("after_hs_out_valid", int'(out_valid), 0);

    // Coefficient write during MAC is ignored: x = {1,2,127,127} -> 894.
    send(1, 894);
    chk("mac_in_ready", int'(in_ready), 0);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'sd5;
    tick();
    coef_we = 1'b0;
    wait_idle();

    // Asynchronous reset with idx == 2; the pending result is discarded.
    send(7, 0);
    tick();
    tick();
    chk("pre_reset_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_out_data", int'(out_data), 0);
    exp_q.delete();
    acc_cyc_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerelease_in_ready", int'(in_ready), 1);
    load_coefs(1, 2, 3, 4);
    send(1, 1);
    wait_idle();

    // c[0]=5 written in the accept cycle of sample 2 over a zero history -> 10.
    do_reset();
    send(2, 10, 1'b1, 5);
    wait_idle();

    // Back-to-back with in_valid held: second accept one cycle after the first handshake.
    do_reset();
    load_coefs(1, 2, 3, 4);
    chk("b2b_start_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 8'sd3;
    exp_q.push_back(3);
    acc_cyc_q.push_back(cyc);
    tick();
    in_data = -8'sd2;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("b2b_in_ready", int'(in_ready), 1);
    chk("b2b_gap", cyc - hs_cyc, 1);
    exp_q.push_back(4);
    acc_cyc_q.push_back(cyc);
    tick();
    in_valid = 1'b0;
    wait_idle();
    tick();
    tick();

    chk("pending_outputs", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
